// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
package icache_pkg;

  localparam int DEFAULT_LINES          = 64;
  localparam int DEFAULT_WORDS_PER_LINE = 4;
  localparam int DEFAULT_ADDR_W         = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REFILL  = 2'd1,
    RESPOND = 2'd2
  } state_e;

  // Bits selecting a 32-bit word inside a line.
  function automatic int word_sel_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  // Bits of byte offset inside a line (word select plus the two byte bits).
  function automatic int offset_w(input int words_per_line);
    return $clog2(words_per_line) + 2;
  endfunction

  // Bits selecting a cache line.
  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction

  // Remaining upper address bits stored as the tag.
  function automatic int tag_w(input int addr_w, input int lines, input int words_per_line);
    return addr_w - index_w(lines) - offset_w(words_per_line);
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/icache_tag_array.sv
// Tag storage plus per-line valid bits. Combinational read port for same-cycle
// lookup, one synchronous write port, and a single-cycle flush of all valids.
module icache_tag_array
  import icache_pkg::*;
#(
  parameter int LINES = DEFAULT_LINES,
  parameter int TAG_W = 22,
  localparam int IDX_W = index_w(LINES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [IDX_W-1:0] rd_index,
  output logic [TAG_W-1:0] rd_tag,
  output logic             rd_valid,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [TAG_W-1:0] wr_tag
);

  logic [TAG_W-1:0] tag_mem [LINES];
  logic [LINES-1:0] valid_q;

  // Valid bits: cleared by reset or flush; a completed refill marks its line.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag storage: written at the end of a refill.
  // NOTE: the tag RAM has no reset; a tag is only trusted when its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index] <= wr_tag;
    end
  end

  assign rd_tag   = tag_mem[rd_index];
  assign rd_valid = valid_q[rd_index];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache. Hits answer one cycle after the request;
// a miss stalls the fetch stage while the whole line is refilled beat by beat,
// then the requested word is returned once from a RESPOND cycle.
module icache_dm
  import icache_pkg::*;
#(
  parameter int LINES          = DEFAULT_LINES,
  parameter int WORDS_PER_LINE = DEFAULT_WORDS_PER_LINE,
  parameter int ADDR_W         = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_address,
  output logic              code_valid,
  output logic [31:0]       code_fetch,
  output logic              misaligned,
  output logic              stall,
  output logic              refill_req,
  output logic [ADDR_W-1:0] refill_address,
  input  logic              refill_valid,
  input  logic [31:0]       refill_data,
  input  logic              flush,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int WO_W  = word_sel_w(WORDS_PER_LINE);
  localparam int OFF_W = offset_w(WORDS_PER_LINE);
  localparam int IDX_W = index_w(LINES);
  localparam int TAG_W = tag_w(ADDR_W, LINES, WORDS_PER_LINE);
  localparam int DW_W  = IDX_W + WO_W;
  localparam logic [WO_W-1:0] LAST_BEAT = WO_W'(WORDS_PER_LINE - 1);

  // Fetch address fields.
  logic [WO_W-1:0]  f_word;
  logic [IDX_W-1:0] f_index;
  logic [TAG_W-1:0] f_tag;
  logic             f_misaligned;

  assign f_word       = fetch_address[2 +: WO_W];
  assign f_index      = fetch_address[OFF_W +: IDX_W];
  assign f_tag        = fetch_address[ADDR_W-1 -: TAG_W];
  assign f_misaligned = (fetch_address[1:0] != 2'b00);

  // State and datapath registers with their next values.
  state_e            state_q,       state_d;
  logic [WO_W-1:0]   req_word_q,    req_word_d;
  logic [IDX_W-1:0]  req_index_q,   req_index_d;
  logic [TAG_W-1:0]  req_tag_q,     req_tag_d;
  logic [WO_W-1:0]   beat_q,        beat_d;
  logic [31:0]       captured_q,    captured_d;
  logic              flush_pend_q,  flush_pend_d;
  logic              code_valid_q,  code_valid_d;
  logic [31:0]       code_fetch_q,  code_fetch_d;
  logic              misaligned_q,  misaligned_d;
  logic [ADDR_W-1:0] refill_addr_q, refill_addr_d;
  logic [31:0]       hit_cnt_q,     hit_cnt_d;
  logic [31:0]       miss_cnt_q,    miss_cnt_d;

  // Control strobes produced by the next-state logic.
  logic tag_we;
  logic data_we;
  logic flush_apply;
  logic lookup_hit;

  // Tag array interface.
  logic [TAG_W-1:0] rd_tag;
  logic             rd_valid;

  // Data storage, addressed as {line index, word in line}.
  logic [31:0]     data_mem [LINES*WORDS_PER_LINE];
  logic [DW_W-1:0] hit_word_addr;
  logic [DW_W-1:0] fill_word_addr;

  assign hit_word_addr  = {f_index, f_word};
  assign fill_word_addr = {req_index_q, beat_q};

  icache_tag_array #(
    .LINES (LINES),
    .TAG_W (TAG_W)
  ) u_tags (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush_apply),
    .rd_index (f_index),
    .rd_tag   (rd_tag),
    .rd_valid (rd_valid),
    .wr_en    (tag_we),
    .wr_index (req_index_q),
    .wr_tag   (req_tag_q)
  );

  // A flush in IDLE takes effect at once; one seen during a refill is held and
  // applied as RESPOND hands back to IDLE, after the refilled word was served.
  assign flush_apply = ((state_q == IDLE) && flush) ||
                       ((state_q == RESPOND) && (flush_pend_q || flush));

  // A lookup coinciding with a flush sees the flushed state and so misses.
  assign lookup_hit = rd_valid && (rd_tag == f_tag) && !flush;

  // Next-state and next-output logic for the IDLE / REFILL / RESPOND controller.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    state_d       = state_q;
    req_word_d    = req_word_q;
    req_index_d   = req_index_q;
    req_tag_d     = req_tag_q;
    beat_d        = beat_q;
    captured_d    = captured_q;
    flush_pend_d  = 1'b0;
    code_valid_d  = 1'b0;
    code_fetch_d  = '0;
    misaligned_d  = 1'b0;
    refill_addr_d = refill_addr_q;
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    tag_we        = 1'b0;
    data_we       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fetch_req) begin
          if (f_misaligned) begin
            code_valid_d = 1'b1;
            misaligned_d = 1'b1;
          end else if (lookup_hit) begin
            code_valid_d = 1'b1;
            code_fetch_d = data_mem[hit_word_addr];
            hit_cnt_d    = sat_inc(hit_cnt_q);
          end else begin
            req_word_d    = f_word;
            req_index_d   = f_index;
            req_tag_d     = f_tag;
            beat_d        = '0;
            refill_addr_d = {fetch_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            miss_cnt_d    = sat_inc(miss_cnt_q);
            state_d       = REFILL;
          end
        end
      end

      REFILL: begin
        flush_pend_d = flush_pend_q || flush;
        if (refill_valid) begin
          data_we = 1'b1;
          beat_d  = beat_q + 1'b1;
          if (beat_q == req_word_q) begin
            captured_d = refill_data;
          end
          if (beat_q == LAST_BEAT) begin
            tag_we       = 1'b1;
            code_valid_d = 1'b1;
            code_fetch_d = (beat_q == req_word_q) ? refill_data : captured_q;
            state_d      = RESPOND;
          end
        end
      end

      RESPOND: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller and output registers; reset aborts any refill in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      req_word_q    <= '0;
      req_index_q   <= '0;
      req_tag_q     <= '0;
      beat_q        <= '0;
      captured_q    <= '0;
      flush_pend_q  <= 1'b0;
      code_valid_q  <= 1'b0;
      code_fetch_q  <= '0;
      misaligned_q  <= 1'b0;
      refill_addr_q <= '0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      req_word_q    <= req_word_d;
      req_index_q   <= req_index_d;
      req_tag_q     <= req_tag_d;
      beat_q        <= beat_d;
      captured_q    <= captured_d;
      flush_pend_q  <= flush_pend_d;
      code_valid_q  <= code_valid_d;
      code_fetch_q  <= code_fetch_d;
      misaligned_q  <= misaligned_d;
      refill_addr_q <= refill_addr_d;
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
    end
  end

  // Line data: each accepted refill beat lands in its word slot.
  always_ff @(posedge clk) begin
    if (data_we) begin
      data_mem[fill_word_addr] <= refill_data;
    end
  end

  assign code_valid     = code_valid_q;
  assign code_fetch     = code_fetch_q;
  assign misaligned     = misaligned_q;
  assign stall          = (state_q != IDLE);
  assign refill_req     = (state_q == REFILL);
  assign refill_address = refill_addr_q;
  assign hit_count      = hit_cnt_q;
  assign miss_count     = miss_cnt_q;

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm at default geometry (64 lines x 4 words):
// directed scenarios followed by randomized fetches against a behavioural model.
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req;
  logic [31:0] fetch_address;
  logic        code_valid;
  logic [31:0] code_fetch;
  logic        misaligned;
  logic        stall;
  logic        refill_req;
  logic [31:0] refill_address;
  logic        refill_valid;
  logic [31:0] refill_data;
  logic        flush;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  always #5 clk = ~clk;

  icache_dm dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_req      (fetch_req),
    .fetch_address  (fetch_address),
    .code_valid     (code_valid),
    .code_fetch     (code_fetch),
    .misaligned     (misaligned),
    .stall          (stall),
    .refill_req     (refill_req),
    .refill_address (refill_address),
    .refill_valid   (refill_valid),
    .refill_data    (refill_data),
    .flush          (flush),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Backing code memory seen by the refill controller (word address -> data).
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  // Reference cache: per line a valid flag, the tag and the four words.
  bit          m_valid [64];
  logic [21:0] m_tag   [64];
  logic [31:0] m_data  [64][4];
  int unsigned m_hits;
  int unsigned m_misses;

  task automatic model_reset();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic model_flush();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_code_valid"}, code_valid, 0);
    check({tag, "_code_fetch"}, code_fetch, 0);
    check({tag, "_misaligned"}, misaligned, 0);
    check({tag, "_stall"}, stall, 0);
    check({tag, "_refill_req"}, refill_req, 0);
    check({tag, "_refill_addr"}, refill_address, 0);
    check({tag, "_hit_count"}, hit_count, 0);
    check({tag, "_miss_count"}, miss_count, 0);
  endtask

  // One complete fetch, called #1 after a rising edge with the cache idle.
  // flush_now raises flush with the request; flush_beat >= 0 pulses flush
  // alongside that refill beat if the fetch turns out to miss.
  task automatic fetch(input logic [31:0] addr, input bit flush_now, input int flush_beat);
    int          idx;
    int          w;
    logic [21:0] tg;
    logic [31:0] base;
    bit          pend;
    idx  = int'(addr[9:4]);
    w    = int'(addr[3:2]);
    tg   = addr[31:10];
    base = {addr[31:4], 4'h0};
    pend = 1'b0;

    fetch_req     = 1'b1;
    fetch_address = addr;
    flush         = flush_now;
    refill_valid  = ($urandom_range(0, 3) == 0);  // stray beat, must be ignored
    refill_data   = $urandom;
    @(posedge clk); #1;
    fetch_req     = 1'b0;
    flush         = 1'b0;
    refill_valid  = 1'b0;
    fetch_address = $urandom;
    if (flush_now) model_flush();

    if (addr[1:0] != 2'b00) begin
      check("mis_valid", code_valid, 1);
      check("mis_flag", misaligned, 1);
      check("mis_data", code_fetch, 0);
      check("mis_norefill", refill_req, 0);
    end else if (m_valid[idx] && m_tag[idx] == tg) begin
      m_hits++;
      check("hit_valid", code_valid, 1);
      check("hit_flag", misaligned, 0);
      check("hit_data", code_fetch, m_data[idx][w]);
      check("hit_norefill", refill_req, 0);
    end else begin
      m_misses++;
      check("miss_refill_req", refill_req, 1);
      check("miss_refill_addr", refill_address, base);
      check("miss_no_valid", code_valid, 0);
      check("miss_stall", stall, 1);
      for (int b = 0; b < 4; b++) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
          check("refill_hold", refill_req, 1);
        end
        refill_valid = 1'b1;
        refill_data  = mem_word(base + 32'(4 * b));
        if (b == flush_beat) begin
          flush = 1'b1;
          pend  = 1'b1;
        end
        @(posedge clk); #1;
        refill_valid = 1'b0;
        flush        = 1'b0;
        if (b < 3) check("refill_no_resp", code_valid, 0);
      end
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      for (int b = 0; b < 4; b++) m_data[idx][b] = mem_word(base + 32'(4 * b));
      check("resp_valid", code_valid, 1);
      check("resp_data", code_fetch, m_data[idx][w]);
      check("resp_misaligned", misaligned, 0);
      check("resp_refill_done", refill_req, 0);
      check("resp_stall", stall, 1);
      @(posedge clk); #1;
      check("resp_pulse", code_valid, 0);
      check("resp_unstall", stall, 0);
      if (pend) model_flush();
    end
    check("hit_count", hit_count, m_hits);
    check("miss_count", miss_count, m_misses);
  endtask

  logic [21:0] tag_pool [4];
  logic [31:0] a;

  initial begin
    tag_pool = '{22'h0, 22'h1, 22'h2A5, 22'h3FFFFF};
    rst_n         = 1'b0;
    fetch_req     = 1'b0;
    fetch_address = '0;
    refill_valid  = 1'b0;
    refill_data   = '0;
    flush         = 1'b0;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Cold miss with known beat data, then a hit on word 2 of the same line.
    mem[32'h40] = 32'h11;
    mem[32'h44] = 32'h22;
    mem[32'h48] = 32'h33;
    mem[32'h4C] = 32'h44;
    fetch(32'h0000_0040, 1'b0, -1);
    fetch(32'h0000_0048, 1'b0, -1);
    // Same index, new tag evicts; the old line then misses again.
    fetch(32'h0000_0440, 1'b0, -1);
    fetch(32'h0000_0040, 1'b0, -1);
    // Misaligned fetch.
    fetch(32'h0000_0042, 1'b0, -1);
    // Flush during a refill: word served once, then the line is gone.
    fetch(32'h0000_0080, 1'b0, 1);
    fetch(32'h0000_0080, 1'b0, -1);
    // Flush in IDLE coinciding with a fetch to a resident line.
    fetch(32'h0000_0084, 1'b0, -1);
    fetch(32'h0000_0084, 1'b1, -1);

    // Randomized traffic over a small address pool so lines get reused.
    for (int i = 0; i < 250; i++) begin
      a[31:10] = tag_pool[$urandom_range(0, 3)];
      a[9:4]   = ($urandom_range(0, 5) == 0) ? 6'd63 : 6'($urandom_range(0, 3));
      a[3:2]   = 2'($urandom_range(0, 3));
      a[1:0]   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      fetch(a, ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1);
    end

    // Reset after two of four beats: immediate abort, later beats ignored.
    fetch_req     = 1'b1;
    fetch_address = 32'h40;
    flush         = 1'b1;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    flush     = 1'b0;
    check("abort_refill_req", refill_req, 1);
    for (int b = 0; b < 2; b++) begin
      refill_valid = 1'b1;
      refill_data  = 32'hDEAD_0000 + 32'(b);
      @(posedge clk); #1;
      refill_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int b = 0; b < 2; b++) begin
      refill_valid = 1'b1;
      refill_data  = 32'hBAD0_0000 + 32'(b);
      @(posedge clk); #1;
      refill_valid = 1'b0;
      check("abort_beat_ignored_req", refill_req, 0);
      check("abort_beat_ignored_valid", code_valid, 0);
    end
    fetch(32'h0000_0040, 1'b0, -1);
    check("abort_refetch_missed", miss_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
